frame_tx_scheduler: RTL and testbench

- Two-requester round-robin scheduler that shares one framing_encoding instance.
- Arbitrates whole frames and emits one PHR byte (frame length), then the PSDU bytes, on phr_psdu_in/phr_psdu_in_valid.
- Paces bytes at the rate the serial encoder consumes them and enforces an inter-frame gap.
- Sits between host-side frame sources and framing_encoding, in the clk domain.

---
 rtl/frame_tx_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_frame_tx_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: two-requester round-robin frame scheduler feeding
// framing_encoding with one PHR length byte followed by the PSDU bytes,
// paced at BYTE_PERIOD cycles per byte, with an IFS_CYCLES idle gap per frame.
module frame_tx_scheduler #(
  parameter int unsigned BYTE_PERIOD = 8,
  parameter int unsigned IFS_CYCLES  = 16,
  parameter int unsigned MAX_LEN     = 127
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic [7:0] len0,
  input  logic [7:0] data0,
  output logic       pop0,
  output logic       done0,
  input  logic       req1,
  input  logic [7:0] len1,
  input  logic [7:0] data1,
  output logic       pop1,
  output logic       done1,
  output logic [7:0] phr_psdu_in,
  output logic       phr_psdu_in_valid,
  output logic [1:0] grant,
  output logic       busy,
  output logic       len_err
);

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned CNT_MAX = (BYTE_PERIOD > IFS_CYCLES) ? BYTE_PERIOD : IFS_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BP_LAST   = CNT_W'(BYTE_PERIOD - 1);
  localparam logic [CNT_W-1:0] IFS_LAST  = CNT_W'(IFS_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_B = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PHR  = 2'd1,
    PSDU = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   len_q, len_d;
  // High when requester 1 was the most recently served (sampled) requester.
  logic               last1_q, last1_d;

  logic [7:0]         byte_d;
  logic               valid_d;
  logic               pop0_d, pop1_d;
  logic               done0_d, done1_d;
  logic               len_err_d;
  logic [1:0]         grant_d;
  logic               busy_d;

  logic               win1;
  logic [LEN_W-1:0]   pick_len;
  logic               owner1;

  assign owner1 = grant[1];

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      rem_q             <= '0;
      len_q             <= '0;
      last1_q           <= 1'b1;
      phr_psdu_in       <= '0;
      phr_psdu_in_valid <= 1'b0;
      pop0              <= 1'b0;
      pop1              <= 1'b0;
      done0             <= 1'b0;
      done1             <= 1'b0;
      len_err           <= 1'b0;
      grant             <= '0;
      busy              <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      rem_q             <= rem_d;
      len_q             <= len_d;
      last1_q           <= last1_d;
      phr_psdu_in       <= byte_d;
      phr_psdu_in_valid <= valid_d;
      pop0              <= pop0_d;
      pop1              <= pop1_d;
      done0             <= done0_d;
      done1             <= done1_d;
      len_err           <= len_err_d;
      grant             <= grant_d;
      busy              <= busy_d;
    end
  end

  // Arbitration, byte pacing and next-value computation for every register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    len_d     = len_q;
    last1_d   = last1_q;
    byte_d    = phr_psdu_in;
    valid_d   = 1'b0;
    pop0_d    = 1'b0;
    pop1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    len_err_d = 1'b0;
    grant_d   = grant;
    win1      = 1'b0;
    pick_len  = len0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Requester 1 wins alone, or on a tie when requester 0 was served last.
          win1     = req1 && (!req0 || !last1_q);
          pick_len = win1 ? len1 : len0;
          len_d    = pick_len;
          last1_d  = win1;
          if ((pick_len == '0) || (pick_len > MAX_LEN_B)) begin
            done0_d   = !win1;
            done1_d   = win1;
            len_err_d = 1'b1;
          end else begin
            grant_d = win1 ? 2'b10 : 2'b01;
            state_d = PHR;
            cnt_d   = '0;
            byte_d  = pick_len;
            valid_d = 1'b1;
          end
        end
      end

      PHR: begin
        if (cnt_q == BP_LAST) begin
          state_d = PSDU;
          cnt_d   = '0;
          rem_d   = len_q;
          byte_d  = owner1 ? data1 : data0;
          valid_d = 1'b1;
          pop0_d  = !owner1;
          pop1_d  = owner1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PSDU: begin
        if (cnt_q == BP_LAST) begin
          cnt_d = '0;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            done0_d = !owner1;
            done1_d = owner1;
            grant_d = '0;
            state_d = GAP;
          end else begin
            byte_d  = owner1 ? data1 : data0;
            valid_d = 1'b1;
            pop0_d  = !owner1;
            pop1_d  = owner1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == IFS_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Testbench for frame_tx_scheduler: table vectors, directed corner sequences
// and randomized traffic, all checked against a frame-timeline reference model.
module tb_frame_tx_scheduler;

  localparam int BP      = 8;
  localparam int IFS     = 16;
  localparam int MAX_LEN = 127;
  localparam int MAXC    = 16384;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, req1;
  logic [7:0] len0, len1, data0, data1;
  logic       pop0, pop1, done0, done1;
  logic [7:0] phr_psdu_in;
  logic       phr_psdu_in_valid;
  logic [1:0] grant;
  logic       busy, len_err;

  frame_tx_scheduler #(.BYTE_PERIOD(BP), .IFS_CYCLES(IFS), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .len0(len0), .data0(data0), .pop0(pop0), .done0(done0),
    .req1(req1), .len1(len1), .data1(data1), .pop1(pop1), .done1(done1),
    .phr_psdu_in(phr_psdu_in), .phr_psdu_in_valid(phr_psdu_in_valid),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Expected outputs per cycle; src: 0/1 = data byte of that requester, 2 = PHR.
  typedef struct packed {
    logic       valid;
    logic [1:0] src;
    logic [7:0] phr;
    logic       pop0, pop1, done0, done1, err;
    logic [1:0] grant;
    logic       busy;
  } exp_t;

  typedef struct {
    logic       r0, r1;
    logic [7:0] l0, l1;
    logic [1:0] g;
    logic       v;
    logic [7:0] b;
    logic       d0, d1, e;
  } vec_t;

  exp_t       expt [MAXC];
  logic [7:0] dh0 [MAXC];
  logic [7:0] dh1 [MAXC];
  int         cyc;
  int         free_at;
  int         m_last;
  int         n_checks = 0;
  int         n_errors = 0;

  int         s_cyc;
  logic       s_valid, s_pop0, s_pop1, s_done0, s_done1, s_err, s_busy;
  logic [7:0] s_byte;
  logic [1:0] s_grant;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic m_clear(input int from);
    for (int i = from; i < MAXC; i++) expt[i] = '0;
  endtask

  // Frame-level model: a grant at cycle t fixes the whole output timeline.
  task automatic model_eval(input int t, input logic r0, input logic r1,
                            input logic [7:0] l0, input logic [7:0] l1);
    int w, len, d, s;
    if (t < free_at || (!r0 && !r1)) return;
    if (r0 && r1) w = (m_last == 0) ? 1 : 0;
    else          w = r1 ? 1 : 0;
    m_last = w;
    len = (w == 1) ? int'(l1) : int'(l0);
    if (len == 0 || len > MAX_LEN) begin
      if (t + 1 < MAXC) begin
        expt[t+1].err = 1'b1;
        if (w == 1) expt[t+1].done1 = 1'b1;
        else        expt[t+1].done0 = 1'b1;
      end
      free_at = t + 1;
      return;
    end
    d = t + 1 + (len + 1) * BP;
    if (t + 1 < MAXC) begin
      expt[t+1].valid = 1'b1;
      expt[t+1].src   = 2'd2;
      expt[t+1].phr   = 8'(len);
    end
    for (int k = 0; k < len; k++) begin
      s = t + 1 + (k + 1) * BP;
      if (s < MAXC) begin
        expt[s].valid = 1'b1;
        expt[s].src   = 2'(w);
        if (w == 1) expt[s].pop1 = 1'b1;
        else        expt[s].pop0 = 1'b1;
      end
    end
    if (d < MAXC) begin
      if (w == 1) expt[d].done1 = 1'b1;
      else        expt[d].done0 = 1'b1;
    end
    for (int c = t + 1; c < d && c < MAXC; c++) expt[c].grant = (w == 1) ? 2'b10 : 2'b01;
    for (int c = t + 1; c < d + IFS && c < MAXC; c++) expt[c].busy = 1'b1;
    free_at = d + IFS;
  endtask

  task automatic compare_cycle();
    exp_t       e;
    logic [7:0] eb;
    e       = expt[cyc];
    s_cyc   = cyc;
    s_valid = phr_psdu_in_valid;
    s_byte  = phr_psdu_in;
    s_pop0  = pop0;
    s_pop1  = pop1;
    s_done0 = done0;
    s_done1 = done1;
    s_err   = len_err;
    s_grant = grant;
    s_busy  = busy;
    chk("valid", 8'(phr_psdu_in_valid), 8'(e.valid));
    if (e.valid) begin
      case (e.src)
        2'd0:    eb = dh0[cyc-1];
        2'd1:    eb = dh1[cyc-1];
        default: eb = e.phr;
      endcase
      chk("byte", phr_psdu_in, eb);
    end
    chk("pop", 8'({pop0, pop1}), 8'({e.pop0, e.pop1}));
    chk("done", 8'({done0, done1}), 8'({e.done0, e.done1}));
    chk("len_err", 8'(len_err), 8'(e.err));
    chk("grant", 8'(grant), 8'(e.grant));
    chk("busy", 8'(busy), 8'(e.busy));
  endtask

  // One clock cycle: drive inputs, update the model, check at the falling edge.
  task automatic step(input logic r0, input logic r1, input logic [7:0] l0,
                      input logic [7:0] l1, input logic [7:0] d0, input logic [7:0] d1);
    req0 = r0; req1 = r1; len0 = l0; len1 = l1; data0 = d0; data1 = d1;
    dh0[cyc] = d0;
    dh1[cyc] = d1;
    model_eval(cyc, r0, r1, l0, l1);
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 8'd0, 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    m_clear(cyc);
    m_last = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_cycle();
      chk("rst_outs", {pop0, pop1, done0, done1, phr_psdu_in_valid, busy, len_err, |grant}, 8'd0);
      chk("rst_byte", phr_psdu_in, 8'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    reset_n = 1'b1;
    free_at = cyc;
  endtask

  function automatic logic [7:0] rand_len();
    int n;
    n = int'($urandom % 64);
    if (n == 0) return 8'd0;
    if (n == 1) return 8'(128 + $urandom % 128);
    if (n == 2) return (($urandom % 8) == 0) ? 8'(MAX_LEN) : 8'(1 + $urandom % 20);
    return 8'(1 + $urandom % 4);
  endfunction

  vec_t       tbl [8];
  logic [7:0] t1_exp [4];
  logic [7:0] rx [4];
  logic [1:0] gseq [4];
  int         t0, nrx, idx, npop, done_at, busy_low, cnt_a, cnt_b, cnt_c, cnt_d, ng;
  logic [1:0] prev_g;
  logic       rq0, rq1;

  initial begin
    tbl[0] = '{1, 0,   3,   0, 2'b01, 1, 8'h03, 0, 0, 0};
    tbl[1] = '{0, 1,   0,   5, 2'b10, 1, 8'h05, 0, 0, 0};
    tbl[2] = '{1, 1,   2,   7, 2'b01, 1, 8'h02, 0, 0, 0};
    tbl[3] = '{0, 1,   0,   0, 2'b00, 0, 8'h00, 0, 1, 1};
    tbl[4] = '{1, 0, 200,   0, 2'b00, 0, 8'h00, 1, 0, 1};
    tbl[5] = '{1, 0, 127,   0, 2'b01, 1, 8'h7f, 0, 0, 0};
    tbl[6] = '{0, 1,   0, 128, 2'b00, 0, 8'h00, 0, 1, 1};
    tbl[7] = '{1, 1,   0,   9, 2'b00, 0, 8'h00, 1, 0, 1};
    t1_exp[0] = 8'h03; t1_exp[1] = 8'hA1; t1_exp[2] = 8'hA2; t1_exp[3] = 8'hA3;

    reset_n = 1'b0;
    req0 = 0; req1 = 0; len0 = 0; len1 = 0; data0 = 0; data1 = 0;
    cyc = 0; free_at = 0; m_last = 1;
    m_clear(0);
    @(posedge clk);
    #1;
    do_reset(2);

    // Table vectors: one request cycle from a fresh reset, outputs one cycle later.
    for (int v = 0; v < 8; v++) begin
      do_reset(1);
      step(tbl[v].r0, tbl[v].r1, tbl[v].l0, tbl[v].l1, 8'h55, 8'h66);
      step(1'b0, 1'b0, 8'd0, 8'd0, 8'h55, 8'h66);
      chk("tbl_grant", 8'(s_grant), 8'(tbl[v].g));
      chk("tbl_valid", 8'(s_valid), 8'(tbl[v].v));
      if (tbl[v].v) chk("tbl_byte", s_byte, tbl[v].b);
      chk("tbl_done", 8'({s_done0, s_done1}), 8'({tbl[v].d0, tbl[v].d1}));
      chk("tbl_err", 8'(s_err), 8'(tbl[v].e));
    end

    // Single len=3 frame; requester steps A1,A2,A3 on each pop.
    do_reset(1);
    t0 = cyc; idx = 0; nrx = 0; npop = 0; done_at = -1; busy_low = -1;
    for (int i = 0; i < 4; i++) rx[i] = 8'h00;
    for (int i = 0; i < 60; i++) begin
      step(i == 0, 1'b0, 8'd3, 8'd0, 8'(8'hA1 + idx), 8'h00);
      if (s_pop0) begin idx++; npop++; end
      if (s_valid && nrx < 4) begin rx[nrx] = s_byte; nrx++; end
      if (s_done0 && done_at < 0) done_at = s_cyc;
      if (!s_busy && s_cyc > t0 + 1 && busy_low < 0) busy_low = s_cyc;
    end
    for (int i = 0; i < 4; i++) chk("t1_rx", rx[i], t1_exp[i]);
    chk("t1_npop", 8'(npop), 8'd3);
    chk("t1_done_at", 8'(done_at - t0), 8'd33);
    chk("t1_busy_low_at", 8'(busy_low - t0), 8'd49);

    // Both held, len=1: grants alternate and pops follow the owner.
    do_reset(1);
    ng = 0; prev_g = 2'b00; cnt_a = 0;
    for (int i = 0; i < 4; i++) gseq[i] = 2'b00;
    for (int i = 0; i < 140; i++) begin
      step(1'b1, 1'b1, 8'd1, 8'd1, 8'($urandom), 8'($urandom));
      if (s_grant != 2'b00 && prev_g == 2'b00 && ng < 4) begin gseq[ng] = s_grant; ng++; end
      if ((s_pop0 && s_grant != 2'b01) || (s_pop1 && s_grant != 2'b10)) cnt_a++;
      prev_g = s_grant;
    end
    chk("rr_g0", 8'(gseq[0]), 8'h01);
    chk("rr_g1", 8'(gseq[1]), 8'h02);
    chk("rr_g2", 8'(gseq[2]), 8'h01);
    chk("rr_g3", 8'(gseq[3]), 8'h02);
    chk("rr_cross_pop", 8'(cnt_a), 8'd0);

    // Invalid lengths on requester 1.
    do_reset(1);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, (i == 0) || (i == 7), 8'd0, (i == 7) ? 8'd200 : 8'd0, 8'h11, 8'h22);
      if (s_err) cnt_a++;
      if (s_done1) cnt_b++;
      if (s_valid) cnt_c++;
      if (s_busy) cnt_d++;
    end
    chk("inv_err_cnt", 8'(cnt_a), 8'd2);
    chk("inv_done1_cnt", 8'(cnt_b), 8'd2);
    chk("inv_valid_cnt", 8'(cnt_c), 8'd0);
    chk("inv_busy_cnt", 8'(cnt_d), 8'd0);

    // Reset during PSDU byte 2 of a len=5 frame, then a tie favours requester 0.
    do_reset(1);
    for (int i = 0; i < 26; i++) step(i == 0, 1'b0, 8'd5, 8'd0, 8'($urandom), 8'h00);
    req0 = 1'b1; req1 = 1'b1; len0 = 8'd2; len1 = 8'd2;
    do_reset(2);
    step(1'b1, 1'b1, 8'd2, 8'd2, 8'h31, 8'h41);
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'h31, 8'h41);
    chk("rst_regrant", 8'(s_grant), 8'h01);
    chk("rst_regrant_phr", s_byte, 8'h02);
    idle(60);

    // req0 dropped right after grant: frame still completes.
    do_reset(1);
    cnt_a = 0; cnt_b = 0;
    step(1'b1, 1'b0, 8'd2, 8'd0, 8'h77, 8'h00);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 8'd9, 8'd0, 8'($urandom), 8'h00);
      if (s_valid) cnt_a++;
      if (s_done0) cnt_b++;
    end
    chk("drop_valid_cnt", 8'(cnt_a), 8'd3);
    chk("drop_done0_cnt", 8'(cnt_b), 8'd1);

    // req1 raised during req0's gap: granted only once the gap ends.
    do_reset(1);
    t0 = cyc; cnt_a = -1; cnt_b = -1;
    for (int i = 0; i < 80; i++) begin
      step(i == 0, (i >= 20) && (i < 40), 8'd1, 8'd2, 8'($urandom), 8'($urandom));
      if (s_grant == 2'b10 && cnt_a < 0) cnt_a = s_cyc;
      if (s_valid && s_cyc > t0 + 1 && s_grant == 2'b10 && cnt_b < 0) cnt_b = s_cyc;
    end
    chk("gap_grant_at", 8'(cnt_a - t0), 8'd34);
    chk("gap_phr_at", 8'(cnt_b - t0), 8'd34);

    // Randomized traffic with occasional resets.
    do_reset(1);
    rq0 = 1'b0; rq1 = 1'b0;
    for (int i = 0; i < 7000; i++) begin
      if (($urandom % 8) == 0) rq0 = ~rq0;
      if (($urandom % 8) == 0) rq1 = ~rq1;
      if (($urandom % 700) == 0) do_reset(1 + int'($urandom % 2));
      else step(rq0 && (i < 5800), rq1 && (i < 5800), rand_len(), rand_len(),
                8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
